// File: rtl/wbm_simple.sv
// wbm_simple: single-outstanding WISHBONE classic initiator.
// A command is taken through a valid/ready handshake, run as one bus
// cycle (with retry/backoff on wb_rty_i), and its result is returned
// through a valid/ready response handshake.
// Optional feature: define WBM_SIMPLE_TIMEOUT_EN to add a watchdog that
// ends a bus cycle with status TIMEOUT after TIMEOUT_CYCLES clocks.
module wbm_simple #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_adr_i,
  input  logic [DATA_WIDTH-1:0]     cmd_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   cmd_sel_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_dat_o,
  output logic [1:0]                rsp_status_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [ADDRESS_WIDTH-1:0]  wb_adr_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  input  logic                      wb_rty_i
);

  localparam int SEL_W   = DATA_WIDTH / 8;
  // At least one bit so MAX_RETRY=0 still yields a legal counter.
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  localparam logic [1:0] STATUS_OK        = 2'b00;
  localparam logic [1:0] STATUS_ERR       = 2'b01;
  localparam logic [1:0] STATUS_RETRY_EXH = 2'b10;

  // Reject parameter sets that cannot describe a working initiator.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wbm_simple: TIMEOUT_CYCLES must be at least 1");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("wbm_simple: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_BACKOFF,
    ST_RESP
  } state_t;

  state_t                     state_q, state_d;
  logic                       cmd_ready_q, cmd_ready_d;
  logic                       cyc_q, cyc_d;
  logic                       we_q, we_d;
  logic [ADDRESS_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]      dat_q, dat_d;
  logic [SEL_W-1:0]           sel_q, sel_d;
  logic [RETRY_W-1:0]         retry_q, retry_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]      rsp_dat_q, rsp_dat_d;
  logic [1:0]                 rsp_status_q, rsp_status_d;

`ifdef WBM_SIMPLE_TIMEOUT_EN
  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);
  logic [WDOG_W-1:0]          wdog_q, wdog_d;
`endif

  // Next-state and next-output logic; every output is taken from a flop.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    retry_d      = retry_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
`ifdef WBM_SIMPLE_TIMEOUT_EN
    wdog_d       = wdog_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          retry_d = '0;
`ifdef WBM_SIMPLE_TIMEOUT_EN
          wdog_d  = '0;
`endif
          cyc_d   = 1'b1;
          state_d = ST_BUS;
        end
      end

      ST_BUS: begin
        if (wb_err_i) begin
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = STATUS_ERR;
          rsp_dat_d    = '0;
          state_d      = ST_RESP;
        end else if (wb_ack_i) begin
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = STATUS_OK;
          rsp_dat_d    = we_q ? '0 : wb_dat_i;
          state_d      = ST_RESP;
        end else if (wb_rty_i) begin
          cyc_d = 1'b0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_ONE;
            state_d = ST_BACKOFF;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = STATUS_RETRY_EXH;
            rsp_dat_d    = '0;
            state_d      = ST_RESP;
          end
        end
`ifdef WBM_SIMPLE_TIMEOUT_EN
        else if (wdog_q == WDOG_LAST) begin
          cyc_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = STATUS_TIMEOUT;
          rsp_dat_d    = '0;
          state_d      = ST_RESP;
        end else begin
          wdog_d = wdog_q + WDOG_ONE;
        end
`endif
      end

      ST_BACKOFF: begin
        cyc_d   = 1'b1;
`ifdef WBM_SIMPLE_TIMEOUT_EN
        wdog_d  = '0;
`endif
        state_d = ST_BUS;
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d  = 1'b0;
          rsp_dat_d    = '0;
          rsp_status_d = STATUS_OK;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs; reset clears everything and drops the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      retry_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= STATUS_OK;
`ifdef WBM_SIMPLE_TIMEOUT_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      retry_q      <= retry_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
`ifdef WBM_SIMPLE_TIMEOUT_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;

endmodule

// File: tb/tb_wbm_simple.sv
// tb_wbm_simple: scoreboard bench for wbm_simple. Expected responses are
// queued when a command is issued and compared when rsp_valid_o appears.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wbm_simple;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MR = 3;
  localparam int TO = 8;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic [SW-1:0] cmd_sel_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_dat_o;
  logic [1:0]    rsp_status_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i, wb_err_i, wb_rty_i;

  typedef struct packed {
    logic [1:0]    status;
    logic [DW-1:0] dat;
  } rsp_t;

  rsp_t sb[$];
  int   pass_count  = 0;
  int   check_count = 0;

  wbm_simple #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .MAX_RETRY     (MR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_status_o(rsp_status_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i),
    .wb_rty_i    (wb_rty_i)
  );

  // Free-running 10-unit clock.
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Issue one command and queue its expected response; returns in the first
  // bus cycle, where wb_cyc_o must already be high.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] adr,
                               input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                               input logic [1:0] exp_status, input logic [DW-1:0] exp_dat);
    int   budget;
    rsp_t exp_rsp;
    exp_rsp.status = exp_status;
    exp_rsp.dat    = exp_dat;
    sb.push_back(exp_rsp);
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    cmd_valid_i = 1'b1;
    budget      = 0;
    while (!cmd_ready_o && budget < 20) begin
      @(negedge clk_i);
      budget++;
    end
    if (!cmd_ready_o) checkOutput("cmd_ready_wait", 64'd0, 64'd1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    checkOutput("cyc_latency", {63'd0, wb_cyc_o}, 64'd1);
    checkOutput("stb_latency", {63'd0, wb_stb_o}, 64'd1);
    checkOutput("busy_not_ready", {63'd0, cmd_ready_o}, 64'd0);
    checkOutput("wb_we", {63'd0, wb_we_o}, {63'd0, we});
    checkOutput("wb_adr", {48'd0, wb_adr_o}, {48'd0, adr});
    checkOutput("wb_sel", {60'd0, wb_sel_o}, {60'd0, sel});
  endtask

  // Keep the bus cycle open for wait_cycles, then answer with the given
  // target response; returns one clock after the response was sampled.
  task automatic serveBus(input int wait_cycles, input logic ack, input logic err,
                          input logic rty, input logic [DW-1:0] rdata,
                          input logic [DW-1:0] exp_wdat);
    for (int i = 0; i < wait_cycles; i++) begin
      checkOutput("bus_wait_cyc", {63'd0, wb_cyc_o}, 64'd1);
      checkOutput("wb_dat_hold", {32'd0, wb_dat_o}, {32'd0, exp_wdat});
      @(negedge clk_i);
    end
    checkOutput("bus_resp_cyc", {63'd0, wb_cyc_o}, 64'd1);
    checkOutput("wb_dat_hold", {32'd0, wb_dat_o}, {32'd0, exp_wdat});
    wb_ack_i = ack;
    wb_err_i = err;
    wb_rty_i = rty;
    wb_dat_i = rdata;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    wb_dat_i = '0;
    checkOutput("cyc_drop", {63'd0, wb_cyc_o}, 64'd0);
  endtask

  // Wait for the response, hold rsp_ready_i low for hold_cycles, compare it
  // against the scoreboard head, then complete the handshake.
  task automatic collectResponse(input int hold_cycles);
    int   budget;
    rsp_t exp_rsp;
    budget = 0;
    while (!rsp_valid_o && budget < 50) begin
      @(negedge clk_i);
      budget++;
    end
    if (!rsp_valid_o) begin
      checkOutput("rsp_valid_wait", 64'd0, 64'd1);
      return;
    end
    for (int h = 0; h < hold_cycles; h++) begin
      checkOutput("rsp_valid_hold", {63'd0, rsp_valid_o}, 64'd1);
      checkOutput("no_accept_in_resp", {63'd0, cmd_ready_o}, 64'd0);
      @(negedge clk_i);
    end
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 64'd1, 64'd0);
      return;
    end
    exp_rsp = sb.pop_front();
    checkOutput("rsp_status", {62'd0, rsp_status_o}, {62'd0, exp_rsp.status});
    checkOutput("rsp_dat", {32'd0, rsp_dat_o}, {32'd0, exp_rsp.dat});
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    checkOutput("rsp_valid_clear", {63'd0, rsp_valid_o}, 64'd0);
    checkOutput("ready_after_rsp", {63'd0, cmd_ready_o}, 64'd1);
  endtask

  // Main stimulus sequence.
  initial begin
    int n;
    int m;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_dat_i   = '0;
    cmd_sel_i   = '0;
    rsp_ready_i = 1'b0;
    wb_dat_i    = '0;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    wb_rty_i    = 1'b0;

    // Reset values
    @(negedge clk_i);
    checkOutput("rst_cmd_ready", {63'd0, cmd_ready_o}, 64'd0);
    checkOutput("rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
    checkOutput("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    checkOutput("rst_rsp_status", {62'd0, rsp_status_o}, 64'd0);
    checkOutput("rst_rsp_dat", {32'd0, rsp_dat_o}, 64'd0);
    checkOutput("rst_wb_adr", {48'd0, wb_adr_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("ready_before_clk", {63'd0, cmd_ready_o}, 64'd0);
    @(negedge clk_i);
    checkOutput("ready_after_clk", {63'd0, cmd_ready_o}, 64'd1);

    // Write, ack in third bus cycle, data held throughout
    applyStimulus(1'b1, 16'h0010, 32'h0000_1234, 4'hF, ST_OK, 32'd0);
    serveBus(2, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234);
    checkOutput("ack_to_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
    collectResponse(0);

    // Read, ack in first bus cycle, response held until rsp_ready_i
    applyStimulus(1'b0, 16'h0020, 32'h0, 4'hF, ST_OK, 32'hDEAD_BEEF);
    serveBus(0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
    checkOutput("ack_to_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
    collectResponse(3);

    // Retry on every attempt: MR+1 bus cycles with one-cycle gaps
    applyStimulus(1'b0, 16'h0030, 32'h0, 4'h3, ST_RTY, 32'd0);
    n = 0;
    for (int k = 0; k <= MR; k++) begin
      n++;
      serveBus(1, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA, 32'h0);
      if (k < MR) begin
        checkOutput("backoff_no_rsp", {63'd0, rsp_valid_o}, 64'd0);
        @(negedge clk_i);
        checkOutput("backoff_one_cycle", {63'd0, wb_cyc_o}, 64'd1);
      end
    end
    checkOutput("retry_attempts", 64'(n), 64'(MR + 1));
    collectResponse(0);

    // err and ack together: err wins, no data
    applyStimulus(1'b0, 16'h0040, 32'h0, 4'hF, ST_ERR, 32'd0);
    serveBus(0, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h0);
    collectResponse(1);

    // One retry, then ack together with rty: ack wins over rty
    applyStimulus(1'b0, 16'h0050, 32'h0, 4'h1, ST_OK, 32'h0BAD_F00D);
    serveBus(0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    @(negedge clk_i);
    serveBus(0, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, 32'h0);
    collectResponse(0);

    // Silent target
`ifdef WBM_SIMPLE_TIMEOUT_EN
    applyStimulus(1'b1, 16'h0060, 32'h7777_0000, 4'hF, ST_TMO, 32'd0);
    n = 0;
    while (wb_cyc_o && n < 40) begin
      n++;
      @(negedge clk_i);
    end
    checkOutput("timeout_cycles", 64'(n), 64'(TO));
    collectResponse(0);
`else
    applyStimulus(1'b1, 16'h0060, 32'h7777_0000, 4'hF, ST_OK, 32'd0);
    n = 0;
    m = 0;
    for (int i = 0; i < 1000; i++) begin
      if (wb_cyc_o) n++;
      if (rsp_valid_o) m++;
      @(negedge clk_i);
    end
    checkOutput("no_timeout_cyc_high", 64'(n), 64'd1000);
    checkOutput("no_timeout_no_rsp", 64'(m), 64'd0);
    serveBus(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h7777_0000);
    collectResponse(0);
`endif

    // Reset during a bus cycle: transaction discarded, no response
    applyStimulus(1'b1, 16'h0070, 32'h1111_2222, 4'hF, ST_OK, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checkOutput("rst_async_cyc", {63'd0, wb_cyc_o}, 64'd0);
    checkOutput("rst_async_rsp", {63'd0, rsp_valid_o}, 64'd0);
    #1;
    rst_i = 1'b0;
    sb.delete();
    n = 0;
    m = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (wb_cyc_o) n++;
      if (rsp_valid_o) m++;
    end
    checkOutput("rst_discard_cyc", 64'(n), 64'd0);
    checkOutput("rst_discard_rsp", 64'(m), 64'd0);

    // Normal command after the reset
    applyStimulus(1'b0, 16'h0080, 32'h0, 4'hC, ST_OK, 32'h1357_9BDF);
    serveBus(1, 1'b1, 1'b0, 1'b0, 32'h1357_9BDF, 32'h0);
    collectResponse(0);

    checkOutput("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Absolute time bound so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/wbm_simple.md
WBM_SIMPLE -- requirements
Module: wbm_simple

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, WISHBONE address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, WISHBONE data width; SEL width is DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_RETRY, default 3, retries allowed after wb_rty_i before giving up.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in clocks.
REQ-005 SHALL have the ports below; the clock is clk_i and the reset is rst_i, one clock, reset asynchronous and active-high.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_adr_i  in  ADDRESS_WIDTH  address.
- cmd_dat_i  in  DATA_WIDTH  write data.
- cmd_sel_i  in  DATA_WIDTH/8  byte selects.
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
- rsp_dat_o  out  DATA_WIDTH  read data; zero for writes and failures.
- rsp_status_o  out  2  00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  WISHBONE classic initiator controls.
- wb_adr_o  out  ADDRESS_WIDTH; wb_dat_o  out  DATA_WIDTH; wb_sel_o  out  DATA_WIDTH/8.
- wb_dat_i  in  DATA_WIDTH; wb_ack_i, wb_err_i, wb_rty_i  in  1  target responses.

Function
REQ-006 SHALL implement states IDLE, BUS, BACKOFF, RESP.
REQ-007 IDLE: cmd_ready_o=1; on cmd_valid_i&cmd_ready_o SHALL register we/adr/dat/sel, clear retry and watchdog counters, go to BUS next cycle.
REQ-008 BUS: wb_cyc_o=wb_stb_o=1 with registered we/adr/dat/sel held stable; cmd_ready_o=0.
REQ-009 Termination priority within one cycle SHALL be err > ack > rty > timeout.
REQ-010 wb_err_i in BUS: drop cyc/stb next cycle, status 01, go RESP.
REQ-011 wb_ack_i in BUS: capture wb_dat_i (reads only), status 00, drop cyc/stb next cycle, go RESP; single-cycle minimum bus cycle (ack in first BUS cycle legal).
REQ-012 wb_rty_i in BUS with retry count < MAX_RETRY: increment count, go BACKOFF (cyc/stb low exactly one cycle), then BUS; watchdog cleared on re-entry.
REQ-013 wb_rty_i with retry count = MAX_RETRY: status 10, go RESP; MAX_RETRY=0 means first rty fails.
REQ-014 RESP: rsp_valid_o=1, rsp_dat_o/rsp_status_o stable until rsp_valid_o&rsp_ready_i, then IDLE; wb_cyc_o=0.
REQ-015 No new command accepted before the response handshake completes (one outstanding transaction).
REQ-016 Retry counter SHALL be wide enough for MAX_RETRY and never wrap.
REQ-017 Latency: command accept to wb_cyc_o high = 1 cycle; ack to rsp_valid_o high = 1 cycle.

Reset
REQ-018 rst_i SHALL asynchronously force IDLE, all wb_* outputs, rsp_valid_o, rsp_dat_o, rsp_status_o and counters to 0; cmd_ready_o=0 while rst_i high, 1 on first clock after release.
REQ-019 Reset mid-transaction SHALL drop wb_cyc_o immediately and discard the transaction with no response.

Configuration
REQ-020 Macro WBM_SIMPLE_TIMEOUT_EN defined: watchdog counts BUS cycles; reaching TIMEOUT_CYCLES with no err/ack/rty ends cycle with status 11, go RESP.
REQ-021 Macro undefined: no watchdog logic; BUS waits indefinitely; status 11 never produced.

Verification
REQ-022 Write 0x1234 adr 0x0010 sel 0xF, ack after 2 cycles -> wb_we_o=1, wb_dat_o=0x1234 held 3 cycles, status 00, rsp_dat_o=0.
REQ-023 Read adr 0x0020, ack first cycle with wb_dat_i=0xDEADBEEF -> rsp_dat_o=0xDEADBEEF, status 00, rsp_valid_o held until rsp_ready_i.
REQ-024 rty on 4 consecutive attempts, MAX_RETRY=3 -> 4 bus cycles, each separated by 1 cyc-low cycle, status 10.
REQ-025 err and ack asserted same cycle -> status 01, rsp_dat_o=0.
REQ-026 With WBM_SIMPLE_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> cyc drops after 8 BUS cycles, status 11; without macro cyc stays high 1000 cycles.
REQ-027 rst_i pulsed during BUS -> wb_cyc_o low asynchronously, no rsp_valid_o, next command completes normally.
